// File: rtl/ifetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, drives the ROM address, registers
// the fetched word into IF/ID, and lends the ROM to a debug port while halted.
module ifetch_sequencer #(
  parameter int unsigned ADDR_W   = 10,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Stall,
  input  logic              Redirect,
  input  logic [31:0]       RedirectPC,
  input  logic              Halt,
  input  logic              Resume,
  input  logic              DbgReq,
  input  logic [ADDR_W-1:0] DbgAddr,
  output logic              DbgAck,
  output logic [31:0]       DbgData,
  output logic [ADDR_W-1:0] RomAddress,
  input  logic [31:0]       RomData,
  output logic [31:0]       PC_IF,
  output logic [31:0]       IR_IF,
  output logic              Valid_IF,
  output logic              Halted,
  output logic [31:0]       FetchCnt
);

  typedef enum logic [1:0] {StRun, StHalted, StDbg} state_e;

  state_e      state;
  logic [31:0] pc;

  // ROM is borrowed by the debug port only during the single DBG cycle;
  // upper PC bits are dropped so fetches wrap modulo the ROM size.
  assign RomAddress = (state == StDbg) ? DbgAddr : pc[ADDR_W+1:2];

  // Sequencer state, PC, IF/ID register and debug read-back.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= StRun;
      pc       <= RESET_PC;
      PC_IF    <= 32'h0;
      IR_IF    <= 32'h0;
      Valid_IF <= 1'b0;
      Halted   <= 1'b0;
      DbgAck   <= 1'b0;
      DbgData  <= 32'h0;
      FetchCnt <= 32'h0;
    end else begin
      DbgAck <= 1'b0;
      case (state)
        StRun: begin
          if (Halt) begin
            // PC holds so fetch resumes exactly where it stopped.
            IR_IF    <= 32'h0;
            Valid_IF <= 1'b0;
            Halted   <= 1'b1;
            state    <= StHalted;
          end else if (Redirect) begin
            // Wrong-path word is dropped even when a stall is pending.
            pc       <= RedirectPC;
            IR_IF    <= 32'h0;
            Valid_IF <= 1'b0;
          end else if (!Stall) begin
            IR_IF    <= RomData;
            PC_IF    <= pc;
            Valid_IF <= 1'b1;
            pc       <= pc + 32'd4;
            FetchCnt <= FetchCnt + 32'd1;
          end
        end
        StHalted: begin
          // A Resume coinciding with DbgReq is intentionally dropped.
          if (DbgReq) begin
            state <= StDbg;
          end else if (Resume) begin
            state  <= StRun;
            Halted <= 1'b0;
          end
        end
        StDbg: begin
          DbgData <= RomData;
          DbgAck  <= 1'b1;
          state   <= StHalted;
        end
        default: begin
          state <= StRun;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_sequencer.sv
// Directed bench for ifetch_sequencer with a combinational ROM model and an
// expected-output scoreboard checked after each rising edge.
module tb_ifetch_sequencer;

  localparam int unsigned ADDR_W = 10;

  logic              clk;
  logic              rst;
  logic              Stall;
  logic              Redirect;
  logic [31:0]       RedirectPC;
  logic              Halt;
  logic              Resume;
  logic              DbgReq;
  logic [ADDR_W-1:0] DbgAddr;
  logic              DbgAck;
  logic [31:0]       DbgData;
  logic [ADDR_W-1:0] RomAddress;
  logic [31:0]       RomData;
  logic [31:0]       PC_IF;
  logic [31:0]       IR_IF;
  logic              Valid_IF;
  logic              Halted;
  logic [31:0]       FetchCnt;

  logic [31:0] rom [1024];

  assign RomData = rom[RomAddress];

  ifetch_sequencer #(
    .ADDR_W  (ADDR_W),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .Stall     (Stall),
    .Redirect  (Redirect),
    .RedirectPC(RedirectPC),
    .Halt      (Halt),
    .Resume    (Resume),
    .DbgReq    (DbgReq),
    .DbgAddr   (DbgAddr),
    .DbgAck    (DbgAck),
    .DbgData   (DbgData),
    .RomAddress(RomAddress),
    .RomData   (RomData),
    .PC_IF     (PC_IF),
    .IR_IF     (IR_IF),
    .Valid_IF  (Valid_IF),
    .Halted    (Halted),
    .FetchCnt  (FetchCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] pc_if;
    logic [31:0] ir_if;
    logic        valid;
    logic        halted;
    logic [31:0] cnt;
    logic        ack;
    logic        chk_data;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic drv(input logic st, input logic rd, input logic [31:0] rpc, input logic hl,
                     input logic rs, input logic dq, input logic [ADDR_W-1:0] da);
    Stall      = st;
    Redirect   = rd;
    RedirectPC = rpc;
    Halt       = hl;
    Resume     = rs;
    DbgReq     = dq;
    DbgAddr    = da;
  endtask

  task automatic ex(input string tag, input logic [31:0] pcif, input logic [31:0] ir,
                    input logic v, input logic h, input logic [31:0] cnt, input logic ack,
                    input logic cd, input logic [31:0] data);
    exp_t e;
    e.tag = tag; e.pc_if = pcif; e.ir_if = ir; e.valid = v; e.halted = h;
    e.cnt = cnt; e.ack = ack; e.chk_data = cd; e.data = data;
    sb.push_back(e);
  endtask

  // Advance one edge, then compare everything queued for this edge.
  task automatic tick;
    exp_t e;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk({e.tag, ".PC_IF"}, PC_IF, e.pc_if);
      chk({e.tag, ".IR_IF"}, IR_IF, e.ir_if);
      chk({e.tag, ".Valid_IF"}, {31'h0, Valid_IF}, {31'h0, e.valid});
      chk({e.tag, ".Halted"}, {31'h0, Halted}, {31'h0, e.halted});
      chk({e.tag, ".FetchCnt"}, FetchCnt, e.cnt);
      chk({e.tag, ".DbgAck"}, {31'h0, DbgAck}, {31'h0, e.ack});
      if (e.chk_data) chk({e.tag, ".DbgData"}, DbgData, e.data);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = 32'h1000_0000 + i * 32'h0001_0101;
    rom[0]    = 32'h2011_0001;
    rom[1]    = 32'h0800_0005;
    rom[117]  = 32'hAE30_0000;
    rom[1023] = 32'h0000_0000;

    rst = 1'b1;
    drv(0, 0, 32'h0, 0, 0, 0, '0);
    ex("reset", 32'h0, 32'h0, 0, 0, 0, 0, 1, 32'h0);
    tick();
    chk("reset.RomAddress", {22'h0, RomAddress}, 32'd0);

    // Straight-line fetch from RESET_PC.
    rst = 1'b0;
    ex("fetch0", 32'h0, 32'h2011_0001, 1, 0, 1, 0, 0, 0);
    tick();
    ex("fetch1", 32'h4, 32'h0800_0005, 1, 0, 2, 0, 0, 0);
    tick();

    // Redirect to 0x14 while PC=8: one bubble, then ROM[5].
    drv(0, 1, 32'h14, 0, 0, 0, '0);
    ex("redir.bubble", 32'h4, 32'h0, 0, 0, 2, 0, 0, 0);
    tick();
    drv(0, 0, 32'h0, 0, 0, 0, '0);
    ex("redir.target", 32'h14, rom[5], 1, 0, 3, 0, 0, 0);
    tick();

    // Move to PC_IF=0x10, then stall 3 cycles.
    drv(0, 1, 32'h10, 0, 0, 0, '0);
    ex("redir10.bubble", 32'h14, 32'h0, 0, 0, 3, 0, 0, 0);
    tick();
    drv(0, 0, 32'h0, 0, 0, 0, '0);
    ex("redir10.target", 32'h10, rom[4], 1, 0, 4, 0, 0, 0);
    tick();
    drv(1, 0, 32'h0, 0, 0, 0, '0);
    for (int i = 0; i < 3; i++) begin
      ex("stall", 32'h10, rom[4], 1, 0, 4, 0, 0, 0);
      tick();
    end
    chk("stall.RomAddress", {22'h0, RomAddress}, 32'd5);

    // Stall and Redirect together: flush wins.
    drv(1, 1, 32'h40, 0, 0, 0, '0);
    ex("stallredir.bubble", 32'h10, 32'h0, 0, 0, 4, 0, 0, 0);
    tick();
    drv(0, 0, 32'h0, 0, 0, 0, '0);
    ex("stallredir.target", 32'h40, rom[16], 1, 0, 5, 0, 0, 0);
    tick();
    ex("adv44", 32'h44, rom[17], 1, 0, 6, 0, 0, 0);
    tick();

    // Halt pulse: PC held at 0x48.
    drv(0, 0, 32'h0, 1, 0, 0, '0);
    ex("halt", 32'h44, 32'h0, 0, 1, 6, 0, 0, 0);
    tick();
    for (int i = 0; i < 10; i++) begin
      drv(i[0], ~i[0], 32'h100 + 32'(i) * 4, i[1], 0, 0, '0);
      ex("halted.ignore", 32'h44, 32'h0, 0, 1, 6, 0, 0, 0);
      tick();
    end
    chk("halted.RomAddress", {22'h0, RomAddress}, 32'd18);

    // Resume restarts at held PC.
    drv(0, 0, 32'h0, 0, 1, 0, '0);
    ex("resume", 32'h44, 32'h0, 0, 0, 6, 0, 0, 0);
    tick();
    drv(0, 0, 32'h0, 0, 0, 0, '0);
    ex("resume.fetch", 32'h48, rom[18], 1, 0, 7, 0, 0, 0);
    tick();
    drv(0, 0, 32'h0, 1, 0, 0, '0);
    ex("halt2", 32'h48, 32'h0, 0, 1, 7, 0, 0, 0);
    tick();

    // Debug read of word 117.
    drv(0, 0, 32'h0, 0, 0, 1, 10'd117);
    ex("dbg117.req", 32'h48, 32'h0, 0, 1, 7, 0, 1, 32'h0);
    tick();
    chk("dbg117.RomAddress", {22'h0, RomAddress}, 32'd117);
    drv(0, 0, 32'h0, 0, 0, 0, 10'd117);
    ex("dbg117.ack", 32'h48, 32'h0, 0, 1, 7, 1, 1, 32'hAE30_0000);
    tick();
    ex("dbg117.hold", 32'h48, 32'h0, 0, 1, 7, 0, 1, 32'hAE30_0000);
    tick();

    // Back-to-back reads: word 1023 then word 2, one every 2 cycles.
    drv(0, 0, 32'h0, 0, 0, 1, 10'd1023);
    ex("dbg1023.req", 32'h48, 32'h0, 0, 1, 7, 0, 1, 32'hAE30_0000);
    tick();
    ex("dbg1023.ack", 32'h48, 32'h0, 0, 1, 7, 1, 1, 32'h0);
    tick();
    drv(0, 0, 32'h0, 0, 0, 1, 10'd2);
    ex("dbg2.req", 32'h48, 32'h0, 0, 1, 7, 0, 1, 32'h0);
    tick();
    drv(0, 0, 32'h0, 0, 0, 0, 10'd2);
    ex("dbg2.ack", 32'h48, 32'h0, 0, 1, 7, 1, 1, rom[2]);
    tick();

    // DbgReq and Resume together: read completes, stays halted.
    drv(0, 0, 32'h0, 0, 1, 1, 10'd117);
    ex("dbgres.req", 32'h48, 32'h0, 0, 1, 7, 0, 1, rom[2]);
    tick();
    drv(0, 0, 32'h0, 0, 0, 0, 10'd117);
    ex("dbgres.ack", 32'h48, 32'h0, 0, 1, 7, 1, 1, 32'hAE30_0000);
    tick();
    ex("dbgres.halted", 32'h48, 32'h0, 0, 1, 7, 0, 1, 32'hAE30_0000);
    tick();

    // Reset during DBG: reset values, no DbgAck.
    drv(0, 0, 32'h0, 0, 0, 1, 10'd1);
    ex("rstdbg.req", 32'h48, 32'h0, 0, 1, 7, 0, 1, 32'hAE30_0000);
    tick();
    rst = 1'b1;
    drv(0, 0, 32'h0, 0, 0, 0, '0);
    ex("rstdbg.reset", 32'h0, 32'h0, 0, 0, 0, 0, 1, 32'h0);
    tick();
    rst = 1'b0;
    ex("rstdbg.fetch0", 32'h0, 32'h2011_0001, 1, 0, 1, 0, 1, 32'h0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ifetch_sequencer.md
# ifetch_sequencer

Instruction-fetch sequencer for the redirection pipeline with BTB. It owns the program counter and drives the address port of the combinational 1024×32 instruction ROM. It registers the fetched word into the IF/ID boundary and applies stall, redirect and halt requests from later stages. When the core is halted, it lends the ROM to a debug read port so the program image can be dumped without a second ROM port.

## Interface
- ADDR_W, 10, ROM word-address width (ROM depth = 2^ADDR_W words)
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- Stall  in  1  hold PC and IF/ID contents (load-use or other hazard)
- Redirect  in  1  flush IF and load RedirectPC (mispredict, jump, branch)
- RedirectPC  in  32  byte address of the corrected fetch target
- Halt  in  1  single-cycle pulse from decode (syscall with $v0=10)
- Resume  in  1  leave the halted state
- DbgReq  in  1  debug ROM read request, sampled only in HALTED
- DbgAddr  in  ADDR_W  debug word address
- DbgAck  out  1  one-cycle pulse: DbgData is valid
- DbgData  out  32  registered ROM word for the debug read
- RomAddress  out  ADDR_W  to ROM Address
- RomData  in  32  from ROM Data, combinational in the same cycle
- PC_IF  out  32  byte PC of the word in IR_IF
- IR_IF  out  32  fetched instruction
- Valid_IF  out  1  IR_IF holds a real instruction
- Halted  out  1  high in the HALTED and DBG states
- FetchCnt  out  32  count of valid fetches since reset

## Operation
- Clock and reset: a single clock `clk`; reset `rst` is synchronous and active-high.
- Internal PC register: 32 bits.
- RomAddress:
  - In DBG state, RomAddress = DbgAddr.
  - Otherwise, RomAddress = PC[ADDR_W+1:2].
  - Upper PC bits are ignored, so addresses wrap modulo the ROM size.
- States and transitions:
  - RUN: normal fetch. Halt → HALTED.
  - HALTED: fetch frozen. DbgReq → DBG. Otherwise Resume → RUN.
  - DBG: exactly one cycle, then → HALTED.
- Priority in RUN, highest first:
  - rst.
  - Halt:
    - PC holds.
    - Valid_IF ← 0 and IR_IF ← 0.
    - Go to HALTED.
  - Redirect:
    - PC ← RedirectPC.
    - Valid_IF ← 0 and IR_IF ← 0; the wrong-path word is dropped even if Stall is high.
  - Stall: PC, PC_IF, IR_IF and Valid_IF all hold.
  - Advance:
    - IR_IF ← RomData.
    - PC_IF ← PC.
    - Valid_IF ← 1.
    - PC ← PC + 4 (32-bit, wraps at 2^32).
    - FetchCnt += 1.
- In HALTED:
  - Stall, Redirect and Halt are ignored.
  - DbgReq has priority over Resume. A Resume given in the same cycle as DbgReq is dropped, so the requester must re-assert it.
- On Resume, fetch restarts at the held PC.
- DBG:
  - DbgData ← RomData, where RomData is the word at DbgAddr.
  - DbgAck ← 1 on the following cycle's outputs.
  - DbgData holds its value until the next debug read.
- FetchCnt wraps at 2^32 and is cleared only by rst.

## Timing
- Reset values:
  - PC = RESET_PC, PC_IF = 0, IR_IF = 0, Valid_IF = 0.
  - State RUN, Halted = 0.
  - DbgAck = 0, DbgData = 0, FetchCnt = 0.
- Reset taken mid-debug or mid-halt returns the block to RUN with the values above.
- Fetch latency: one cycle. The ROM word at PC appears on IR_IF the cycle after PC is presented.
  - First valid instruction: the first edge with rst low, ROM[RESET_PC>>2] with Valid_IF = 1.
- Redirect penalty: one bubble. Valid_IF = 0 for one cycle, then ROM[RedirectPC>>2] is presented.
- Halted rises the cycle after the Halt pulse.
- Debug read:
  - DbgReq sampled in HALTED at edge N.
  - DBG during cycle N..N+1.
  - DbgAck = 1 for exactly one cycle after edge N+1.
  - Back-to-back debug reads: one every 2 cycles.

## Test plan
- Reset then run, ROM[0]=0x20110001, ROM[1]=0x08000005:
  - After the first edge: IR_IF=0x20110001, PC_IF=0, Valid_IF=1.
  - Next edge: IR_IF=0x08000005, PC_IF=4.
  - FetchCnt=2.
- Redirect to 0x14 while fetching PC=8:
  - Next cycle Valid_IF=0.
  - Following cycle PC_IF=0x14 and IR_IF=ROM[5].
  - FetchCnt does not count the bubble.
- Stall held 3 cycles at PC_IF=0x10:
  - IR_IF, PC_IF and FetchCnt frozen.
  - Stall and Redirect together: flush wins, Valid_IF=0, next PC_IF=RedirectPC.
- Halt pulse:
  - Halted=1 and Valid_IF=0 the next cycle.
  - PC_IF and FetchCnt unchanged for 10 cycles, with Stall and Redirect toggling.
  - Resume: fetch restarts at the held PC with the correct IR_IF.
- Debug reads while halted:
  - DbgAddr=117 gives DbgData=0xAE300000 with a single DbgAck pulse 2 edges after the request.
  - DbgAddr=1023 gives DbgData=0.
  - DbgReq and Resume together: the read completes and the block stays HALTED.
- rst asserted during DBG: all outputs return to their reset values the next cycle and no DbgAck is issued.
